// File: rtl/mem_reg_arbiter.sv
// mem_reg_arbiter
//    Clocked front-end that shares one dual-rail memory register among N
//    requesters. It round-robin arbitrates the requests, encodes the winning
//    word onto the dual-rail link and runs the link handshake against the
//    register's asynchronous completion ack.
//
// Parameters
//    ENC    : "FP" four-phase return-to-zero, "TP" two-phase transition
//    WIDTH  : data bits per word
//    N      : number of requesters (2..16)
//    TO_CYC : watchdog limit in clk cycles (watchdog build only)
//
// Ports
//    clk       in   system clock
//    rst       in   asynchronous active-low reset
//    req       in   [N]         level request per requester
//    req_data  in   [N*WIDTH]   word of requester i at [i*WIDTH +: WIDTH]
//    gnt       out  [N]         one-hot owner of the current transaction
//    done      out              one-cycle completion pulse
//    link_data out  [2*WIDTH]   dual-rail word, bit i on rails [2i+1:2i]
//    link_ack  in               asynchronous completion ack from the register
//    err       out              sticky watchdog error flag
//
// Optional feature
//    Define MEM_REG_ARB_TIMEOUT_EN to build the handshake watchdog. Without
//    it err is tied low and a stuck ack stalls the arbiter.

module mem_reg_arbiter #(
   parameter     ENC    = "FP",
   parameter int WIDTH  = 8,
   parameter int N      = 4,
   parameter int TO_CYC = 1023
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         req,
   input  logic [N*WIDTH-1:0]   req_data,
   output logic [N-1:0]         gnt,
   output logic                 done,
   output logic [2*WIDTH-1:0]   link_data,
   input  logic                 link_ack,
   output logic                 err
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
   localparam bit IS_TP = (ENC == "TP");

   // Reject configurations the link or the arbiter cannot support.
   if ((ENC != "FP") && (ENC != "TP")) begin : g_badEnc
      $error("mem_reg_arbiter: ENC must be \"FP\" or \"TP\"");
   end
   if ((N < 2) || (N > 16)) begin : g_badN
      $error("mem_reg_arbiter: N must be in 2..16");
   end
   if (TO_CYC < 1) begin : g_badTimeout
      $error("mem_reg_arbiter: TO_CYC must be at least 1");
   end

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      RTZ   = 2'd2,
      DONE  = 2'd3
   } stateT;

   stateT              r_state;
   stateT              w_stateNxt;
   logic [N-1:0]       r_gnt;
   logic [N-1:0]       w_gntNxt;
   logic               r_done;
   logic               w_doneNxt;
   logic [2*WIDTH-1:0] r_linkData;
   logic [2*WIDTH-1:0] w_linkNxt;
   logic [2*WIDTH-1:0] w_encWord;
   logic [IDX_W-1:0]   r_rrPtr;
   logic [IDX_W-1:0]   w_rrNxt;
   logic [IDX_W-1:0]   r_winner;
   logic [IDX_W-1:0]   w_winnerNxt;
   logic [IDX_W-1:0]   w_pick;
   logic [IDX_W-1:0]   w_cand;
   logic [IDX_W-1:0]   w_rrAfterWinner;
   logic [WIDTH-1:0]   w_pickData;
   logic               w_anyReq;
   logic               r_ackMeta;
   logic               r_ackS;
   logic               r_phase;
   logic               w_phaseNxt;

`ifdef MEM_REG_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TO_CYC + 1);
   logic [WD_W-1:0]    r_wdog;
   logic [WD_W-1:0]    w_wdogNxt;
   logic               r_err;
   logic               w_errNxt;
`endif

   // Two-flop synchroniser; every handshake decision looks at r_ackS only.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ackMeta <= 1'b0;
         r_ackS    <= 1'b0;
      end else begin
         r_ackMeta <= link_ack;
         r_ackS    <= r_ackMeta;
      end
   end

   // Round-robin pick: scanning downward lets the lowest offset from the
   // pointer overwrite the others, so the first set request at or above
   // the pointer (with wrap) wins.
   always_comb begin
      w_anyReq = |req;
      w_pick   = r_rrPtr;
      w_cand   = '0;
      for (int k = N - 1; k >= 0; k--) begin
         w_cand = IDX_W'((int'(r_rrPtr) + k) % N);
         if (req[w_cand]) begin
            w_pick = w_cand;
         end
      end
   end

   assign w_pickData      = req_data[int'(w_pick)*WIDTH +: WIDTH];
   assign w_rrAfterWinner = (r_winner == IDX_W'(N - 1)) ? '0 : r_winner + IDX_W'(1);

   // Dual-rail encoding of the winning word. Four-phase drives a fresh
   // codeword from the all-zero spacer; two-phase flips one rail per bit
   // relative to what the link currently shows.
   always_comb begin
      w_encWord = IS_TP ? r_linkData : '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (IS_TP) begin
            if (w_pickData[i]) begin
               w_encWord[2*i+1] = ~r_linkData[2*i+1];
            end else begin
               w_encWord[2*i] = ~r_linkData[2*i];
            end
         end else begin
            w_encWord[2*i+1] = w_pickData[i];
            w_encWord[2*i]   = ~w_pickData[i];
         end
      end
   end

   // Next-state and registered-output logic of the handshake FSM.
   always_comb begin
      w_stateNxt  = r_state;
      w_gntNxt    = r_gnt;
      w_doneNxt   = 1'b0;
      w_linkNxt   = r_linkData;
      w_rrNxt     = r_rrPtr;
      w_winnerNxt = r_winner;
      w_phaseNxt  = r_phase;
`ifdef MEM_REG_ARB_TIMEOUT_EN
      w_wdogNxt   = r_wdog;
      w_errNxt    = r_err;
`endif

      case (r_state)
         IDLE: begin
            if (w_anyReq) begin
               w_winnerNxt = w_pick;
               w_gntNxt    = N'(1) << w_pick;
               w_linkNxt   = w_encWord;
               w_stateNxt  = DRIVE;
            end
         end
         DRIVE: begin
            if (IS_TP) begin
               // The register answers a transition word by toggling ack.
               if (r_ackS != r_phase) begin
                  w_phaseNxt = ~r_phase;
                  w_doneNxt  = 1'b1;
                  w_stateNxt = DONE;
               end
            end else if (r_ackS) begin
               w_linkNxt  = '0;
               w_stateNxt = RTZ;
            end
         end
         RTZ: begin
            if (!r_ackS) begin
               w_doneNxt  = 1'b1;
               w_stateNxt = DONE;
            end
         end
         DONE: begin
            w_gntNxt   = '0;
            w_rrNxt    = w_rrAfterWinner;
            w_stateNxt = IDLE;
         end
         default: begin
            w_stateNxt = IDLE;
         end
      endcase

`ifdef MEM_REG_ARB_TIMEOUT_EN
      // Watchdog restarts on every state change and only runs while the
      // arbiter waits on the register. A normal exit takes priority.
      if (w_stateNxt != r_state) begin
         w_wdogNxt = '0;
      end else if ((r_state == DRIVE) || (r_state == RTZ)) begin
         if (r_wdog == WD_W'(TO_CYC - 1)) begin
            w_errNxt   = 1'b1;
            w_linkNxt  = '0;
            w_gntNxt   = '0;
            w_rrNxt    = w_rrAfterWinner;
            w_stateNxt = IDLE;
            w_wdogNxt  = '0;
         end else begin
            w_wdogNxt = r_wdog + WD_W'(1);
         end
      end
`endif
   end

   // State and output registers; reset abandons any transaction in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_done     <= 1'b0;
         r_linkData <= '0;
         r_rrPtr    <= '0;
         r_winner   <= '0;
         r_phase    <= 1'b0;
      end else begin
         r_state    <= w_stateNxt;
         r_gnt      <= w_gntNxt;
         r_done     <= w_doneNxt;
         r_linkData <= w_linkNxt;
         r_rrPtr    <= w_rrNxt;
         r_winner   <= w_winnerNxt;
         r_phase    <= w_phaseNxt;
      end
   end

`ifdef MEM_REG_ARB_TIMEOUT_EN
   // Watchdog counter and sticky error flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_wdog <= '0;
         r_err  <= 1'b0;
      end else begin
         r_wdog <= w_wdogNxt;
         r_err  <= w_errNxt;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign gnt       = r_gnt;
   assign done      = r_done;
   assign link_data = r_linkData;

endmodule

// File: tb/tb_mem_reg_arbiter.sv
// tb_mem_reg_arbiter
//    Directed bench for mem_reg_arbiter. One four-phase and one two-phase
//    instance (WIDTH=4, N=4, TO_CYC=20) share clock and reset. Outputs are
//    sampled on the falling edge, inputs change on the falling edge.

module tb_mem_reg_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [3:0]  fpReq;
   logic [15:0] fpData;
   logic [3:0]  fpGnt;
   logic        fpDone;
   logic [7:0]  fpLink;
   logic        fpAck;
   logic        fpErr;
   logic        fpAuto;
   logic        fpAckMan;

   logic [3:0]  tpReq;
   logic [15:0] tpData;
   logic [3:0]  tpGnt;
   logic        tpDone;
   logic [7:0]  tpLink;
   logic        tpAck;
   logic        tpErr;

   int          nChecks = 0;
   int          nErrors = 0;
   int          doneCount;
   logic [31:0] expGnt;
   logic [31:0] expLink;
   logic [7:0]  fpCode [4];

   always #5 clk = ~clk;

   // Four-phase register model: ack follows "word present" immediately.
   assign fpAck = fpAuto ? (|fpLink) : fpAckMan;

   mem_reg_arbiter #(.ENC("FP"), .WIDTH(4), .N(4), .TO_CYC(20)) dutFp (
      .clk(clk), .rst(rst), .req(fpReq), .req_data(fpData), .gnt(fpGnt),
      .done(fpDone), .link_data(fpLink), .link_ack(fpAck), .err(fpErr)
   );

   mem_reg_arbiter #(.ENC("TP"), .WIDTH(4), .N(4), .TO_CYC(20)) dutTp (
      .clk(clk), .rst(rst), .req(tpReq), .req_data(tpData), .gnt(tpGnt),
      .done(tpDone), .link_data(tpLink), .link_ack(tpAck), .err(tpErr)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      assert (observed === expected) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] newReq, input logic newAck);
      fpReq    = newReq;
      fpAckMan = newAck;
   endtask

   task automatic waitNeg(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // Requester words 3,5,A,C and their four-phase codewords.
      fpData    = {4'hC, 4'hA, 4'h5, 4'h3};
      fpCode[0] = 8'h5A;
      fpCode[1] = 8'h66;
      fpCode[2] = 8'h99;
      fpCode[3] = 8'hA5;
      fpAuto    = 1'b0;
      tpReq     = 4'h0;
      tpData    = 16'h0000;
      tpAck     = 1'b0;
      applyStimulus(4'hF, 1'b0);
      doneCount = 0;
      #1 rst = 1'b0;

      // Reset held with every request active.
      for (int i = 0; i < 3; i++) begin
         waitNeg(1);
         checkOutput("reset gnt", 32'(fpGnt), 32'h0);
         checkOutput("reset done", 32'(fpDone), 32'h0);
         checkOutput("reset link", 32'(fpLink), 32'h0);
         checkOutput("reset err", 32'(fpErr), 32'h0);
      end
      checkOutput("reset tp gnt", 32'(tpGnt), 32'h0);
      checkOutput("reset tp link", 32'(tpLink), 32'h0);

      // Release with auto-ack: round-robin 1,2,4,8,1, period 8 cycles.
      rst    = 1'b1;
      fpAuto = 1'b1;
      for (int t = 0; t < 40; t++) begin
         int slot;
         int idx;
         slot = t % 8;
         idx  = (t / 8) % 4;
         waitNeg(1);
         expGnt  = (slot <= 6) ? (32'h1 << idx) : 32'h0;
         expLink = (slot <= 2) ? 32'(fpCode[idx]) : 32'h0;
         checkOutput("rr gnt", 32'(fpGnt), expGnt);
         checkOutput("rr done", 32'(fpDone), 32'(slot == 6));
         checkOutput("rr link", 32'(fpLink), expLink);
         checkOutput("rr onehot", 32'($onehot0(fpGnt)), 32'h1);
         if (fpDone === 1'b1) doneCount++;
         if (t == 32) applyStimulus(4'h0, 1'b0);
      end
      checkOutput("rr done count", 32'(doneCount), 32'd5);
      checkOutput("rr err", 32'(fpErr), 32'h0);
      waitNeg(1);
      checkOutput("rr idle gnt", 32'(fpGnt), 32'h0);

      // Single four-phase write from requester 2, ack one cycle late.
      fpAuto = 1'b0;
      applyStimulus(4'b0100, 1'b0);
      waitNeg(1);
      checkOutput("fp gnt", 32'(fpGnt), 32'h4);
      checkOutput("fp codeword", 32'(fpLink), 32'h99);
      waitNeg(1);
      applyStimulus(4'b0100, 1'b1);
      waitNeg(2);
      checkOutput("fp link before sync", 32'(fpLink), 32'h99);
      waitNeg(1);
      checkOutput("fp rtz link", 32'(fpLink), 32'h0);
      applyStimulus(4'b0100, 1'b0);
      waitNeg(2);
      checkOutput("fp done early", 32'(fpDone), 32'h0);
      checkOutput("fp gnt held", 32'(fpGnt), 32'h4);
      waitNeg(1);
      checkOutput("fp done", 32'(fpDone), 32'h1);
      applyStimulus(4'h0, 1'b0);
      waitNeg(1);
      checkOutput("fp done single", 32'(fpDone), 32'h0);
      checkOutput("fp gnt released", 32'(fpGnt), 32'h0);

      // Two two-phase writes of word 1 from requester 0.
      tpReq  = 4'b0001;
      tpData = 16'h0001;
      waitNeg(1);
      checkOutput("tp gnt 1", 32'(tpGnt), 32'h1);
      checkOutput("tp link 1", 32'(tpLink), 32'h56);
      checkOutput("tp bit0 rails 1", 32'(tpLink[1:0]), 32'h2);
      tpAck = 1'b1;
      waitNeg(2);
      checkOutput("tp done early 1", 32'(tpDone), 32'h0);
      waitNeg(1);
      checkOutput("tp done 1", 32'(tpDone), 32'h1);
      tpReq = 4'b0000;
      waitNeg(1);
      checkOutput("tp gnt idle", 32'(tpGnt), 32'h0);
      checkOutput("tp link held", 32'(tpLink), 32'h56);
      tpReq = 4'b0001;
      waitNeg(1);
      checkOutput("tp gnt 2", 32'(tpGnt), 32'h1);
      checkOutput("tp link 2", 32'(tpLink), 32'h00);
      checkOutput("tp bit0 rails 2", 32'(tpLink[1:0]), 32'h0);
      tpAck = 1'b0;
      waitNeg(2);
      checkOutput("tp done early 2", 32'(tpDone), 32'h0);
      waitNeg(1);
      checkOutput("tp done 2", 32'(tpDone), 32'h1);
      tpReq = 4'b0000;
      waitNeg(1);
      checkOutput("tp gnt end", 32'(tpGnt), 32'h0);

      // Reset in DRIVE; rr pointer 0 afterwards favours requester 1 over 3.
      applyStimulus(4'b0010, 1'b0);
      waitNeg(1);
      checkOutput("mid gnt", 32'(fpGnt), 32'h2);
      checkOutput("mid link", 32'(fpLink), 32'h66);
      waitNeg(1);
      rst = 1'b0;
      #1;
      checkOutput("mid async gnt", 32'(fpGnt), 32'h0);
      checkOutput("mid async link", 32'(fpLink), 32'h0);
      checkOutput("mid async done", 32'(fpDone), 32'h0);
      checkOutput("mid async err", 32'(fpErr), 32'h0);
      applyStimulus(4'b1010, 1'b0);
      waitNeg(1);
      checkOutput("mid held gnt", 32'(fpGnt), 32'h0);
      rst    = 1'b1;
      fpAuto = 1'b1;
      waitNeg(1);
      checkOutput("mid regrant", 32'(fpGnt), 32'h2);
      checkOutput("mid regrant link", 32'(fpLink), 32'h66);
      waitNeg(6);
      checkOutput("mid done", 32'(fpDone), 32'h1);
      checkOutput("mid done gnt", 32'(fpGnt), 32'h2);
      waitNeg(1);
      checkOutput("mid gap gnt", 32'(fpGnt), 32'h0);
      waitNeg(1);
      checkOutput("mid next gnt", 32'(fpGnt), 32'h8);
      checkOutput("mid next link", 32'(fpLink), 32'hA5);
      applyStimulus(4'h0, 1'b0);
      waitNeg(8);
      checkOutput("mid final gnt", 32'(fpGnt), 32'h0);
      checkOutput("mid final done", 32'(fpDone), 32'h0);

`ifdef MEM_REG_ARB_TIMEOUT_EN
      // Stuck ack: watchdog fires 20 cycles after DRIVE entry.
      fpAuto = 1'b0;
      applyStimulus(4'b0011, 1'b0);
      waitNeg(1);
      checkOutput("wd gnt", 32'(fpGnt), 32'h1);
      checkOutput("wd link", 32'(fpLink), 32'h5A);
      for (int k = 1; k < 20; k++) begin
         waitNeg(1);
         checkOutput("wd no done", 32'(fpDone), 32'h0);
      end
      checkOutput("wd err early", 32'(fpErr), 32'h0);
      checkOutput("wd gnt before", 32'(fpGnt), 32'h1);
      waitNeg(1);
      checkOutput("wd err", 32'(fpErr), 32'h1);
      checkOutput("wd gnt cleared", 32'(fpGnt), 32'h0);
      checkOutput("wd link cleared", 32'(fpLink), 32'h0);
      checkOutput("wd done", 32'(fpDone), 32'h0);
      waitNeg(1);
      checkOutput("wd next gnt", 32'(fpGnt), 32'h2);
      checkOutput("wd next link", 32'(fpLink), 32'h66);
      checkOutput("wd err sticky", 32'(fpErr), 32'h1);
`else
      checkOutput("fp err tied", 32'(fpErr), 32'h0);
      checkOutput("tp err tied", 32'(tpErr), 32'h0);
`endif

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
